crossroad_scheduler: RTL

CROSSROAD_SCHEDULER -- requirements
Module: crossroad_scheduler

---
 rtl/crossroad_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/crossroad_scheduler.sv
// Four-way intersection light controller: Moore FSM with a dwell counter and sticky requests.
// Optional pedestrian walk phase is compiled in with `define CROSSROAD_PED_EN.
module crossroad_scheduler #(
  parameter int GREEN_MIN = 4,
  parameter int YELLOW    = 2,
  parameter int ALL_RED   = 1,
  parameter int WALK      = 3
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_ns_req,
  input  logic       i_ew_req,
  input  logic       i_ped_req,
  output logic       o_ns_red,
  output logic       o_ns_yellow,
  output logic       o_ns_green,
  output logic       o_ew_red,
  output logic       o_ew_yellow,
  output logic       o_ew_green,
  output logic       o_walk,
  output logic [2:0] o_phase
);

  typedef enum logic [2:0] {
    ST_ALL_RED   = 3'd0,
    ST_NS_GREEN  = 3'd1,
    ST_NS_YELLOW = 3'd2,
    ST_EW_GREEN  = 3'd3,
    ST_EW_YELLOW = 3'd4,
    ST_WALK      = 3'd5
  } state_t;

  localparam logic [7:0] GREEN_LAST   = 8'(GREEN_MIN - 1);
  localparam logic [7:0] YELLOW_LAST  = 8'(YELLOW - 1);
  localparam logic [7:0] ALL_RED_LAST = 8'(ALL_RED - 1);
  localparam logic [7:0] WALK_LAST    = 8'(WALK - 1);

  state_t     state;
  logic [7:0] count;
  logic       next_dir;
  logic       ns_pend;
  logic       ew_pend;
  logic       ped_pend;
  logic       ns_leave;
  logic       ew_leave;

`ifndef CROSSROAD_PED_EN
  logic unused_ped;
  assign unused_ped = i_ped_req;
  assign ped_pend   = 1'b0;
`endif

  // A green is only abandoned once its minimum dwell is met and someone else is waiting.
  assign ns_leave = (count >= GREEN_LAST) && (ew_pend || ped_pend);
  assign ew_leave = (count >= GREEN_LAST) && (ns_pend || ped_pend);

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= ST_ALL_RED;
      count    <= '0;
      next_dir <= 1'b0;
      ns_pend  <= 1'b0;
      ew_pend  <= 1'b0;
`ifdef CROSSROAD_PED_EN
      ped_pend <= 1'b0;
`endif
    end else begin
      if (count != 8'hFF) count <= count + 8'd1;
      if (i_ns_req && state != ST_NS_GREEN) ns_pend <= 1'b1;
      if (i_ew_req && state != ST_EW_GREEN) ew_pend <= 1'b1;
`ifdef CROSSROAD_PED_EN
      if (i_ped_req) ped_pend <= 1'b1;
`endif
      // Entry clears below are written after the sets so they win on the entry cycle.
      case (state)
        ST_ALL_RED: begin
          if (count == ALL_RED_LAST) begin
            count <= '0;
            if (ped_pend) begin
              state <= ST_WALK;
`ifdef CROSSROAD_PED_EN
              ped_pend <= 1'b0;
`endif
            end else if (!next_dir) begin
              state   <= ST_NS_GREEN;
              ns_pend <= 1'b0;
            end else begin
              state   <= ST_EW_GREEN;
              ew_pend <= 1'b0;
            end
          end
        end
        ST_NS_GREEN: begin
          if (ns_leave) begin
            state    <= ST_NS_YELLOW;
            count    <= '0;
            next_dir <= ~next_dir;
          end
        end
        ST_NS_YELLOW: begin
          if (count == YELLOW_LAST) begin
            state <= ST_ALL_RED;
            count <= '0;
          end
        end
        ST_EW_GREEN: begin
          if (ew_leave) begin
            state    <= ST_EW_YELLOW;
            count    <= '0;
            next_dir <= ~next_dir;
          end
        end
        ST_EW_YELLOW: begin
          if (count == YELLOW_LAST) begin
            state <= ST_ALL_RED;
            count <= '0;
          end
        end
        ST_WALK: begin
          if (count == WALK_LAST) begin
            count <= '0;
            if (!next_dir) begin
              state   <= ST_NS_GREEN;
              ns_pend <= 1'b0;
            end else begin
              state   <= ST_EW_GREEN;
              ew_pend <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_ALL_RED;
          count <= '0;
        end
      endcase
    end
  end

  // Lamps are a pure decode of the state register; unknown codes show both reds.
  always_comb begin
    o_ns_red    = 1'b1;
    o_ns_yellow = 1'b0;
    o_ns_green  = 1'b0;
    o_ew_red    = 1'b1;
    o_ew_yellow = 1'b0;
    o_ew_green  = 1'b0;
    o_walk      = 1'b0;
    case (state)
      ST_NS_GREEN: begin
        o_ns_red   = 1'b0;
        o_ns_green = 1'b1;
      end
      ST_NS_YELLOW: begin
        o_ns_red    = 1'b0;
        o_ns_yellow = 1'b1;
      end
      ST_EW_GREEN: begin
        o_ew_red   = 1'b0;
        o_ew_green = 1'b1;
      end
      ST_EW_YELLOW: begin
        o_ew_red    = 1'b0;
        o_ew_yellow = 1'b1;
      end
`ifdef CROSSROAD_PED_EN
      ST_WALK: o_walk = 1'b1;
`endif
      default: ;
    endcase
  end

  assign o_phase = state;

endmodule
